imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Write-side counterpart to the Fetch stage. Fetch reads instruction words; this block writes them.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit MIPS instruction words.
- Writes each assembled word to consecutive instruction-memory word addresses.
- Asserts fetch_hold while loading so the Fetch stage and the R-type datapath stay stalled until the program image is complete.

Parameters:
- ADDR_WIDTH, 8, instruction-memory word-address width.
- MAX_WORDS, 256, maximum words per load. Must be ≤ 2**ADDR_WIDTH.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a load; sampled only in IDLE or DONE.
- load_len  input  ADDR_WIDTH+1  number of words to load; sampled with start.
- in_valid  input  1  byte source has data.
- in_data  input  8  byte payload.
- in_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  one-cycle instruction-memory write strobe.
- mem_addr  output  ADDR_WIDTH  word address of the write.
- mem_wdata  output  32  assembled instruction word.
- busy  output  1  high in RECV and WRITE.
- done  output  1  high in DONE.
- error  output  1  sticky; high after a rejected start.
- fetch_hold  output  1  equals busy; drives the Fetch stall.
- words_written  output  ADDR_WIDTH+1  count of words written in the current or last load.

Behaviour:
- Reset (rst=1 at an edge): state IDLE. All outputs 0; byte counter, word counter and assembly register cleared.
- Reset applied mid-load: any partial word is discarded, no write occurs, and state returns to IDLE on that edge.
- FSM states: IDLE, RECV, WRITE, DONE.
- IDLE/DONE, start=1:
  - If load_len==0 or load_len>MAX_WORDS: error←1, go to IDLE, no other change.
  - Otherwise: error←0, done←0, words_written←0, word counter←0, byte counter←0, latch load_len, go to RECV.
- Start while busy: ignored.
- RECV:
  - in_ready=1.
  - A byte is accepted when in_valid && in_ready at the edge.
  - Big-endian assembly: byte 0→[31:24], byte 1→[23:16], byte 2→[15:8], byte 3→[7:0].
  - in_valid low: hold state; no timeout.
  - On acceptance of the 4th byte: go to WRITE.
- WRITE (exactly one cycle):
  - in_ready=0, mem_we=1, mem_addr=word counter, mem_wdata=assembled word.
  - Next edge: words_written+1, word counter+1, byte counter←0.
  - Then go to DONE if that was word load_len-1, else RECV.
- Throughput: ≤1 word per 5 cycles. With in_valid held high, the first write occurs 4 cycles after the first accepting edge.
- mem_addr and mem_wdata hold their last values when mem_we=0. mem_we is never high outside WRITE.
- DONE:
  - done=1, fetch_hold=0, in_ready=0.
  - Stays in DONE until rst or a new valid start.
- Word counter does not wrap. The largest load (MAX_WORDS) writes addresses 0..MAX_WORDS-1.
- Bytes offered outside RECV are not consumed (in_ready=0). The source must hold them.

Decomposition:
- Shared package (mips_pkg):
  - loader state encoding (IDLE=2'd0, RECV=2'd1, WRITE=2'd2, DONE=2'd3)
  - INSTR_WIDTH=32
  - BYTES_PER_WORD=4
  - the funct constants used by DPTR (ADD=6'h20, SUB=6'h22)
- One natural sub-module: imem_word_packer. It holds the byte counter and shift register and produces word_valid; the FSM and address counter stay in imem_loader.

Test Plan:
- Basic two-word load: rst 2 cycles; start with load_len=2; stream bytes 01 E9 A0 22 00 AF 78 20 with in_valid held high. Required: mem_we pulses at addr 0 with 0x01E9A022 (sub $20,$15,$9) and at addr 1 with 0x00AF7820 (add $15,$5,$15). Then done=1, words_written=2, fetch_hold falls to 0 in the same cycle done rises.
- Source stalls: same image with in_valid low for 3 cycles between each byte. Required: identical writes, no extra mem_we pulses, fetch_hold=1 throughout.
- Rejected starts: start with load_len=0, and separately with load_len=257. Required: error=1, state IDLE, no mem_we, in_ready stays 0. A subsequent valid start clears error.
- Reset mid-word: after 2 bytes of word 1 are accepted, assert rst for 1 cycle. Required: no write of the partial word, all outputs 0. A fresh start with load_len=1 and bytes DE AD BE EF writes 0xDEADBEEF at addr 0.
- Start while busy: pulse start with load_len=5 during RECV of a 2-word load. Required: ignored; load completes with words_written=2.
- Back-to-back loads: from DONE, start with load_len=1, bytes 00 00 00 00. Required: done drops the next cycle, one write of 0x00000000 to addr 0, done=1 again.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: instruction geometry, R-type funct codes and the
// instruction-memory loader state encoding.
package mips_pkg;

  localparam int INSTR_WIDTH    = 32;
  localparam int BYTES_PER_WORD = 4;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;

  typedef enum logic [1:0] {
    LD_IDLE  = 2'd0,
    LD_RECV  = 2'd1,
    LD_WRITE = 2'd2,
    LD_DONE  = 2'd3
  } loader_state_t;

  // A load length is usable when it is non-zero and fits the image limit.
  function automatic logic len_ok(input int unsigned len, input int unsigned max_words);
    return (len != 0) && (len <= max_words);
  endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Collects a big-endian byte stream into 32-bit instruction words; the fourth
// byte bypasses the lane registers so the word is ready on its accepting edge.
module imem_word_packer
  import mips_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   accept,
  input  logic [7:0]             in_data,
  output logic [INSTR_WIDTH-1:0] word,
  output logic                   word_valid
);

  logic [1:0] byte_cnt_reg;
  logic [7:0] lane_reg [BYTES_PER_WORD-1];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      byte_cnt_reg <= '0;
      for (int i = 0; i < BYTES_PER_WORD - 1; i++) lane_reg[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < BYTES_PER_WORD - 1; i++)
        if (byte_cnt_reg == 2'(i)) lane_reg[i] <= in_data;
      byte_cnt_reg <= byte_cnt_reg + 2'd1;
    end
  end

  // Lane 0 is the most significant byte of the instruction.
  genvar gi;
  generate
    for (gi = 0; gi < BYTES_PER_WORD - 1; gi++) begin : g_lane
      assign word[INSTR_WIDTH-1-8*gi -: 8] = lane_reg[gi];
    end
  endgenerate
  assign word[7:0]  = in_data;
  assign word_valid = accept && (byte_cnt_reg == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Streams a program image into instruction memory one word per WRITE cycle and
// holds Fetch stalled while the image is incomplete.
module imem_loader
  import mips_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_WORDS  = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_WIDTH:0]    load_len,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   in_ready,
  output logic                   mem_we,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [INSTR_WIDTH-1:0] mem_wdata,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic                   fetch_hold,
  output logic [ADDR_WIDTH:0]    words_written
);

  localparam logic [ADDR_WIDTH:0] ONE = 1;

  loader_state_t          state_reg;
  logic [ADDR_WIDTH:0]    len_reg;
  logic [ADDR_WIDTH:0]    words_written_reg;
  logic [ADDR_WIDTH-1:0]  mem_addr_reg;
  logic [INSTR_WIDTH-1:0] mem_wdata_reg;
  logic                   error_reg;

  logic                   accept;
  logic                   start_ok;
  logic                   len_good;
  logic                   packer_clr;
  logic [INSTR_WIDTH-1:0] word;
  logic                   word_valid;

  assign accept     = in_valid && (state_reg == LD_RECV);
  assign start_ok   = start && ((state_reg == LD_IDLE) || (state_reg == LD_DONE));
  assign len_good   = len_ok(32'(load_len), MAX_WORDS);
  assign packer_clr = (start_ok && len_good) || (state_reg == LD_WRITE);

  imem_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (packer_clr),
    .accept     (accept),
    .in_data    (in_data),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= LD_IDLE;
      len_reg           <= '0;
      words_written_reg <= '0;
      mem_addr_reg      <= '0;
      mem_wdata_reg     <= '0;
      error_reg         <= 1'b0;
    end else begin
      case (state_reg)
        LD_IDLE, LD_DONE: begin
          if (start_ok) begin
            if (!len_good) begin
              error_reg <= 1'b1;
              state_reg <= LD_IDLE;
            end else begin
              error_reg         <= 1'b0;
              words_written_reg <= '0;
              len_reg           <= load_len;
              state_reg         <= LD_RECV;
            end
          end
        end
        LD_RECV: begin
          // Address and data are captured here so they hold once WRITE ends.
          if (word_valid) begin
            mem_addr_reg  <= words_written_reg[ADDR_WIDTH-1:0];
            mem_wdata_reg <= word;
            state_reg     <= LD_WRITE;
          end
        end
        LD_WRITE: begin
          words_written_reg <= words_written_reg + ONE;
          state_reg <= (words_written_reg == len_reg - ONE) ? LD_DONE : LD_RECV;
        end
        default: state_reg <= LD_IDLE;
      endcase
    end
  end

  assign in_ready      = (state_reg == LD_RECV);
  assign mem_we        = (state_reg == LD_WRITE);
  assign busy          = (state_reg == LD_RECV) || (state_reg == LD_WRITE);
  assign done          = (state_reg == LD_DONE);
  assign fetch_hold    = busy;
  assign error         = error_reg;
  assign mem_addr      = mem_addr_reg;
  assign mem_wdata     = mem_wdata_reg;
  assign words_written = words_written_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued when a load is
// started and matched against every observed mem_we pulse.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [8:0]  load_len;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        error;
  logic        fetch_hold;
  logic [8:0]  words_written;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;
  wr_t sb[$];

  always #5 clk = ~clk;

  imem_loader #(.ADDR_WIDTH(8), .MAX_WORDS(256)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .load_len      (load_len),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .fetch_hold    (fetch_hold),
    .words_written (words_written)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Write monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin : mon
    wr_t e;
    if (mem_we === 1'b1) begin
      if (sb.size() == 0) begin
        check_eq("extra_we", {24'd0, mem_addr}, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        $display("write addr=%0d data=%h (exp addr=%0d data=%h)", mem_addr, mem_wdata, e.addr, e.data);
        check_eq("wr_addr", {24'd0, mem_addr}, {24'd0, e.addr});
        check_eq("wr_data", mem_wdata, e.data);
        check_eq("wr_hold", {31'd0, fetch_hold}, 32'd1);
      end
    end
  end

  task automatic expect_wr(input logic [7:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic start_load(input logic [8:0] len);
    @(negedge clk);
    start    = 1'b1;
    load_len = len;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (gap) begin
      check_eq("stall_hold", {31'd0, fetch_hold}, 32'd1);
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (!in_ready && t < 64) begin
      @(negedge clk);
      t++;
    end
    if (t >= 64) check_eq("ready_timeout", t, 0);
    @(posedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    send_byte(w[31:24], gap);
    send_byte(w[23:16], gap);
    send_byte(w[15:8], gap);
    send_byte(w[7:0], gap);
  endtask

  task automatic wait_done(input logic [8:0] exp_ww);
    int t;
    @(negedge clk);
    in_valid = 1'b0;
    t = 0;
    while (!done && t < 40) begin
      check_eq("hold_before_done", {31'd0, fetch_hold}, 32'd1);
      @(negedge clk);
      t++;
    end
    check_eq("done", {31'd0, done}, 32'd1);
    check_eq("done_hold", {31'd0, fetch_hold}, 32'd0);
    check_eq("done_busy", {31'd0, busy}, 32'd0);
    check_eq("done_ready", {31'd0, in_ready}, 32'd0);
    check_eq("words_written", {23'd0, words_written}, {23'd0, exp_ww});
    check_eq("sb_empty", sb.size(), 0);
  endtask

  task automatic check_idle_zero(input string tag);
    check_eq({tag, "_we"},    {31'd0, mem_we},     32'd0);
    check_eq({tag, "_addr"},  {24'd0, mem_addr},   32'd0);
    check_eq({tag, "_wdata"}, mem_wdata,           32'd0);
    check_eq({tag, "_busy"},  {31'd0, busy},       32'd0);
    check_eq({tag, "_done"},  {31'd0, done},       32'd0);
    check_eq({tag, "_err"},   {31'd0, error},      32'd0);
    check_eq({tag, "_hold"},  {31'd0, fetch_hold}, 32'd0);
    check_eq({tag, "_rdy"},   {31'd0, in_ready},   32'd0);
    check_eq({tag, "_ww"},    {23'd0, words_written}, 32'd0);
  endtask

  task automatic reject(input logic [8:0] len);
    start_load(len);
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (3) begin
      @(negedge clk);
      check_eq("rej_err",  {31'd0, error},    32'd1);
      check_eq("rej_busy", {31'd0, busy},     32'd0);
      check_eq("rej_done", {31'd0, done},     32'd0);
      check_eq("rej_rdy",  {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    load_len = '0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (2) @(negedge clk);
    check_idle_zero("reset");
    rst = 1'b0;

    // Two-word image, source never stalls.
    expect_wr(8'd0, 32'h01E9A022);
    expect_wr(8'd1, 32'h00AF7820);
    start_load(9'd2);
    send_word(32'h01E9A022, 0);
    send_word(32'h00AF7820, 0);
    wait_done(9'd2);

    // Same image with three idle cycles before every byte.
    expect_wr(8'd0, 32'h01E9A022);
    expect_wr(8'd1, 32'h00AF7820);
    start_load(9'd2);
    send_word(32'h01E9A022, 3);
    send_word(32'h00AF7820, 3);
    wait_done(9'd2);

    // Out-of-range lengths are refused; a good start clears the error.
    reject(9'd0);
    reject(9'd257);
    expect_wr(8'd0, 32'h12345678);
    start_load(9'd1);
    @(negedge clk);
    check_eq("err_clear", {31'd0, error}, 32'd0);
    send_word(32'h12345678, 0);
    wait_done(9'd1);

    // Reset in the middle of the second word drops the partial word.
    expect_wr(8'd0, 32'hCAFEF00D);
    start_load(9'd2);
    send_word(32'hCAFEF00D, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_zero("midrst");
    repeat (3) @(negedge clk);
    check_eq("midrst_sb", sb.size(), 0);
    expect_wr(8'd0, 32'hDEADBEEF);
    start_load(9'd1);
    send_word(32'hDEADBEEF, 0);
    wait_done(9'd1);

    // A start pulse during RECV must not restart or resize the load.
    expect_wr(8'd0, 32'h01E9A022);
    expect_wr(8'd1, 32'h00AF7820);
    start_load(9'd2);
    send_byte(8'h01, 0);
    send_byte(8'hE9, 0);
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b1;
    load_len = 9'd5;
    @(posedge clk);
    #1 start = 1'b0;
    send_byte(8'hA0, 0);
    send_byte(8'h22, 0);
    send_word(32'h00AF7820, 0);
    wait_done(9'd2);

    // Back-to-back load straight out of DONE.
    expect_wr(8'd0, 32'h00000000);
    start_load(9'd1);
    @(negedge clk);
    check_eq("b2b_done_drop", {31'd0, done}, 32'd0);
    check_eq("b2b_busy", {31'd0, busy}, 32'd1);
    send_word(32'h00000000, 0);
    wait_done(9'd1);

    repeat (3) @(negedge clk);
    check_eq("final_sb", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
